halt_request: RTL

HALT_REQUEST -- requirements
Module: halt_request

---
 rtl/halt_request_pkg.sv | 20 ++
 rtl/halt_request_if.sv | 25 ++
 rtl/halt_request_inflight_counter.sv | 27 ++
 rtl/halt_request.sv | 104 ++++++++++
 4 files changed

// File: rtl/halt_request_pkg.sv
// rtl/halt_request_pkg.sv - shared CPU halt types, defaults and width helper
package halt_request_pkg;

    // Encoding is shared with the halt block's monitors; keep values stable.
    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_DRAIN    = 3'd1,
        ST_SIGNAL   = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_HALTED   = 3'd4
    } halt_state_t;

    localparam int                          DEFAULT_OPCODE_W    = 6;
    localparam logic [DEFAULT_OPCODE_W-1:0] DEFAULT_HALT_OPCODE = 6'h3F;

    function automatic int count_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/halt_request_if.sv
// rtl/halt_request_if.sv - issue/retire/halt handshake bundle
interface halt_request_if import halt_request_pkg::*; #(
    parameter int OPCODE_W = DEFAULT_OPCODE_W,
    parameter int CNT_W    = count_width(4)
);
    logic                issue_valid;
    logic [OPCODE_W-1:0] issue_opcode;
    logic                retire;
    logic                halt_program;
    logic                fetch_stall;
    logic                halt_signal;
    logic                halted;
    logic [CNT_W-1:0]    inflight;
    logic                err;

    modport master (
        output issue_valid, issue_opcode, retire, halt_program,
        input  fetch_stall, halt_signal, halted, inflight, err
    );

    modport slave (
        input  issue_valid, issue_opcode, retire, halt_program,
        output fetch_stall, halt_signal, halted, inflight, err
    );
endinterface

// File: rtl/halt_request_inflight_counter.sv
// rtl/halt_request_inflight_counter.sv - saturating in-flight up/down counter
module inflight_counter import halt_request_pkg::*; #(
    parameter int MAX_COUNT = 4,
    parameter int CNT_W     = count_width(MAX_COUNT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             underflow
);
    // Error strobes only fire for a lone inc/dec; a paired inc+dec is a no-op.
    assign overflow  = inc && !dec && (count == CNT_W'(MAX_COUNT));
    assign underflow = dec && !inc && (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec && !overflow) begin
            count <= count + CNT_W'(1);
        end else if (dec && !inc && !underflow) begin
            count <= count - CNT_W'(1);
        end
    end
endmodule

// File: rtl/halt_request.sv
// rtl/halt_request.sv - drain in-flight work, then run the halt handshake
module halt_request import halt_request_pkg::*; #(
    parameter int                  OPCODE_W     = DEFAULT_OPCODE_W,
    parameter logic [OPCODE_W-1:0] HALT_OPCODE  = DEFAULT_HALT_OPCODE,
    parameter int                  MAX_INFLIGHT = 4,
    parameter int                  ACK_TIMEOUT  = 16
) (
    input  logic          clk,
    input  logic          rst,
    halt_request_if.slave bus
);
    localparam int               CNT_W    = count_width(MAX_INFLIGHT);
    localparam int               TMO_W    = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    halt_state_t      state;
    logic [TMO_W-1:0] tmo_cnt;
    logic             stall_q;
    logic             err_q;
    logic             halt_signal_q;
    logic             halted_q;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;
    logic             is_halt;
    logic             halt_issue;
    logic             count_inc;
    logic             proto_err;

    assign is_halt    = (bus.issue_opcode == HALT_OPCODE);
    assign halt_issue = (state == ST_RUN) && bus.issue_valid && is_halt;
    assign count_inc  = (state == ST_RUN) && bus.issue_valid && !is_halt;
    assign proto_err  = overflow || underflow
                     || (bus.issue_valid && !is_halt && (state != ST_RUN))
                     || (bus.halt_program && (state != ST_WAIT_ACK) && (state != ST_HALTED));

    inflight_counter #(
        .MAX_COUNT (MAX_INFLIGHT),
        .CNT_W     (CNT_W)
    ) u_inflight (
        .clk       (clk),
        .rst       (rst),
        .inc       (count_inc),
        .dec       (bus.retire),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_RUN;
            tmo_cnt       <= '0;
            stall_q       <= 1'b0;
            err_q         <= 1'b0;
            halt_signal_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            halt_signal_q <= 1'b0;
            if (proto_err) begin
                err_q <= 1'b1;
            end
            case (state)
                ST_RUN: begin
                    if (halt_issue) begin
                        state   <= ST_DRAIN;
                        stall_q <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (count == '0) begin
                        state         <= ST_SIGNAL;
                        halt_signal_q <= 1'b1;
                    end
                end
                ST_SIGNAL: begin
                    state   <= ST_WAIT_ACK;
                    tmo_cnt <= '0;
                end
                ST_WAIT_ACK: begin
                    // An acknowledge on the timeout cycle wins over a re-pulse.
                    if (bus.halt_program) begin
                        state    <= ST_HALTED;
                        halted_q <= 1'b1;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state         <= ST_SIGNAL;
                        tmo_cnt       <= '0;
                        halt_signal_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_RUN;
            endcase
        end
    end

    assign bus.fetch_stall = stall_q || halt_issue;
    assign bus.halt_signal = halt_signal_q;
    assign bus.halted      = halted_q;
    assign bus.inflight    = count;
    assign bus.err         = err_q;
endmodule
